// File: rtl/spi_pkg.sv
// Shared SPI definitions: FSM state encoding and link defaults common to master and slave.
package spi_pkg;

  localparam int          SPI_WIDTH   = 8;
  localparam logic [7:0]  SPI_IDLE_TX = 8'hFF;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } spi_state_e;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser for an asynchronous input, followed by rise/fall detection
// on the last two synchronised samples. STAGES must be at least 2.
module spi_sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {STAGES{RST_VAL}};
      prev_q <= RST_VAL;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign rise_o =  sync_q[STAGES-1] & ~prev_q;
  assign fall_o = ~sync_q[STAGES-1] &  prev_q;

endmodule

// File: rtl/spi_slave.sv
// SPI responder (SCLK idle high, shift on fall, sample on rise, MSB first, SS active-low).
// Optional MISO output-enable port is added when SPI_SLAVE_MISO_OE_EN is defined.
module spi_slave
  import spi_pkg::*;
#(
  parameter int               WIDTH       = SPI_WIDTH,
  parameter int               SYNC_STAGES = 2,
  parameter logic [WIDTH-1:0] IDLE_TX     = SPI_IDLE_TX
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             SCLK,
  input  logic             SS,
  input  logic             MOSI,
  output logic             MISO,
`ifdef SPI_SLAVE_MISO_OE_EN
  output logic             MISO_oe,
`endif
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  output logic             busy,
  output logic             frame_err
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  logic sclk_rise, sclk_fall, ss_rise, ss_fall;
  logic [SYNC_STAGES-1:0] mosi_sync_q;
  logic                   mosi_s;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sclk_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .d_i    (SCLK),
    .rise_o (sclk_rise),
    .fall_o (sclk_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_ss_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .d_i    (SS),
    .rise_o (ss_rise),
    .fall_o (ss_fall)
  );

  // MOSI needs no edge detect; it is sampled when the aligned SCLK rise is seen.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) mosi_sync_q <= '0;
    else        mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], MOSI};
  end
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

  spi_state_e       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] tx_shift_q;
  logic [WIDTH-2:0] rx_shift_q;
  logic [WIDTH-1:0] rx_data_q;
  logic             rx_valid_q;
  logic             frame_err_q;
  logic             first_edge_q;
  logic [WIDTH-1:0] tx_buf_q;
  logic             tx_full_q;

  logic             tx_accept;
  logic             word_done;
  logic             frame_start;
  logic             reload;
  logic [WIDTH-1:0] reload_word;
  logic [WIDTH-1:0] rx_word;

  assign tx_accept   = tx_valid && !tx_full_q;
  assign frame_start = (state_q == IDLE) && ss_fall;
  assign word_done   = (state_q == ACTIVE) && !ss_rise && sclk_rise &&
                       (cnt_q == CNT_W'(WIDTH - 1));
  assign reload      = frame_start || word_done;
  // A word offered in the same cycle as a reload bypasses the buffer.
  assign reload_word = tx_full_q ? tx_buf_q : (tx_valid ? tx_data : IDLE_TX);
  assign rx_word     = {rx_shift_q, mosi_s};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_buf_q  <= '0;
      tx_full_q <= 1'b0;
    end else if (reload) begin
      tx_full_q <= 1'b0;
    end else if (tx_accept) begin
      tx_buf_q  <= tx_data;
      tx_full_q <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      tx_shift_q   <= '0;
      rx_shift_q   <= '0;
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
      frame_err_q  <= 1'b0;
      first_edge_q <= 1'b0;
    end else begin
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (ss_fall) begin
            state_q      <= ACTIVE;
            cnt_q        <= '0;
            tx_shift_q   <= reload_word;
            first_edge_q <= 1'b1;
          end
        end
        ACTIVE: begin
          if (ss_rise) begin
            state_q <= IDLE;
            if (cnt_q != '0) frame_err_q <= 1'b1;
          end else begin
            if (sclk_fall) begin
              if (first_edge_q) first_edge_q <= 1'b0;
              else              tx_shift_q   <= {tx_shift_q[WIDTH-2:0], 1'b0};
            end
            if (sclk_rise) begin
              rx_shift_q <= rx_word[WIDTH-2:0];
              if (word_done) begin
                rx_data_q    <= rx_word;
                rx_valid_q   <= 1'b1;
                cnt_q        <= '0;
                tx_shift_q   <= reload_word;
                first_edge_q <= 1'b1;
              end else begin
                cnt_q <= cnt_q + 1'b1;
              end
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign MISO      = (state_q == ACTIVE) ? tx_shift_q[WIDTH-1] : 1'b1;
  assign busy      = (state_q == ACTIVE);
  assign tx_ready  = !tx_full_q;
  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;

`ifdef SPI_SLAVE_MISO_OE_EN
  assign MISO_oe = (state_q == ACTIVE);
`endif

endmodule
